// File: rtl/regfile_pkg.sv
// Register file shared constants.
// Architectural register indices and default widths.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;

  localparam int ZERO_IDX = 0;
  localparam int V0_IDX   = 2;
  localparam int A0_IDX   = 4;
  localparam int RA_IDX   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port of regfile_mp.
// Ports: addr in; regs_flat/pend state in; wr/link
// commit info in; data/busy out.
// Same-cycle forwarding when REGFILE_BYPASS_EN is set.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int RA_REG   = RA_IDX
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
  input  logic [(2**ADDR_W)-1:0]        pend,
  input  logic                          wr_ok,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          link_ok,
  input  logic [DATA_W-1:0]             link_data,
  output logic [DATA_W-1:0]             data,
  output logic                          busy
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] RA_A   = ADDR_W'(RA_REG);

  always_comb begin
    data = regs_flat[addr*DATA_W +: DATA_W];
    busy = pend[addr];
    if (ZERO_REG != 0 && addr == ZERO_A) begin
      data = '0;
      busy = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes the link target
    if (link_ok && addr == RA_A) begin
      data = link_data;
      busy = 1'b0;
    end else if (wr_ok && addr == wr_addr) begin
      data = wr_data;
      busy = 1'b0;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_ok, wr_addr, wr_data,
                        link_ok, link_data, RA_A};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with link port and
// pending scoreboard.
// Ports: clk, rst (async high); rd_addr/rd_data/
// rd_busy (NUM_RD ports); wr_*; link_*; alloc_*;
// tap_v0/tap_a0/tap_ra.
// Macro REGFILE_BYPASS_EN: same-cycle forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1,
  parameter int RA_REG   = RA_IDX,
  parameter int V0_REG   = V0_IDX,
  parameter int A0_REG   = A0_IDX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [DATA_W-1:0]        tap_v0,
  output logic [DATA_W-1:0]        tap_a0,
  output logic [DATA_W-1:0]        tap_ra
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] RA_A   = ADDR_W'(RA_REG);
  localparam bit RA_DEAD = (ZERO_REG != 0) && (RA_REG == 0);
  localparam bit ZMASK   = (ZERO_REG != 0);

  logic [DATA_W-1:0]       regs [DEPTH];
  logic [DEPTH*DATA_W-1:0] regs_flat;
  logic [DEPTH-1:0]        pend;
  logic [DEPTH-1:0]        pend_nxt;

  logic link_ok;
  logic wr_ok;
  logic alloc_ok;

  // Commit qualifiers: reset discards, r0 guarded,
  // link beats a general write to the same register.
  assign link_ok  = !rst && link_en && !RA_DEAD;
  assign wr_ok    = !rst && wr_en
                 && !(ZMASK && wr_addr == ZERO_A)
                 && !(link_ok && wr_addr == RA_A);
  assign alloc_ok = !rst && alloc_en
                 && !(ZMASK && alloc_addr == ZERO_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
      end
      if (link_ok) begin
        regs[RA_A] <= link_data;
      end
    end
  end

  // Alloc applied last: a new producer outlives a
  // write landing on the same edge.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) begin
      pend_nxt[wr_addr] = 1'b0;
    end
    if (link_ok) begin
      pend_nxt[RA_A] = 1'b0;
    end
    if (alloc_ok) begin
      pend_nxt[alloc_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .RA_REG   (RA_REG)
    ) u_rp (
      .addr      (rd_addr[g*ADDR_W +: ADDR_W]),
      .regs_flat (regs_flat),
      .pend      (pend),
      .wr_ok     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .link_ok   (link_ok),
      .link_data (link_data),
      .data      (rd_data[g*DATA_W +: DATA_W]),
      .busy      (rd_busy[g])
    );
  end

  localparam logic [ADDR_W-1:0] TAP_A [3] = '{
    ADDR_W'(V0_REG), ADDR_W'(A0_REG), ADDR_W'(RA_REG)
  };

  logic [DATA_W-1:0] taps [3];

  always_comb begin
    for (int t = 0; t < 3; t++) begin
      taps[t] = regs[TAP_A[t]];
      if (ZMASK && TAP_A[t] == ZERO_A) begin
        taps[t] = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (link_ok && TAP_A[t] == RA_A) begin
        taps[t] = link_data;
      end else if (wr_ok && TAP_A[t] == wr_addr) begin
        taps[t] = wr_data;
      end
`endif
    end
  end

  assign tap_v0 = taps[0];
  assign tap_a0 = taps[1];
  assign tap_ra = taps[2];

endmodule
